fila_dados: RTL and testbench
=============================

Name: fila_dados

Overview:
- Circular FIFO queue placed directly downstream of the 8-bit deserializer.
- Captures each word the deserializer presents with data_ready, then returns the ack that releases the deserializer for the next word.
- Buffers up to DEPTH words and hands them out one at a time to the consumer on a dequeue request.
- Exposes occupancy (len_out) and full/empty flags.

Parameters:
- WIDTH, 8, word width; must match the deserializer data_out width.
- DEPTH, 8, number of entries; power of two, minimum 2.
- LEN_W, 4, width of len_out; must hold 0..DEPTH, i.e. log2(DEPTH)+1.

Ports:
- clock_10KHz  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears the block immediately).
- data_in  input  WIDTH  word from the deserializer data_out.
- data_ready_in  input  1  deserializer data_ready; high means data_in holds a complete word.
- ack_out  output  1  to the deserializer ack_in; high means the word has been taken.
- dequeue_in  input  1  consumer request to pop the head word.
- data_out  output  WIDTH  last popped word, registered.
- len_out  output  LEN_W  current number of stored words.
- full_out  output  1  high when len_out == DEPTH.
- empty_out  output  1  high when len_out == 0.

Behaviour:
- Reset (reset=0, asynchronous), taking effect immediately:
  - state=IDLE; ack_out=0; data_out=0; len_out=0; full_out=0; empty_out=1.
  - Head and tail pointers = 0; storage contents are don't-care.
- Reset mid-handshake: the word is not stored. ack_out drops at once, and the block restarts in IDLE.
- Input FSM, two states:
  - IDLE: if data_ready_in=1 and the queue is not full (evaluated at the start of the cycle):
    - write data_in to mem[tail]; tail = tail+1 mod DEPTH; len +1;
    - go to ACK; ack_out=1 from the next cycle.
  - IDLE: if data_ready_in=1 and the queue is full, stay in IDLE with ack_out=0. The deserializer stalls until space frees.
  - ACK: ack_out held at 1 while data_ready_in=1. When data_ready_in=0, go to IDLE with ack_out=0 registered on that edge.
  - The ACK state guarantees exactly one enqueue per deserializer word, whatever the clock ratio.
- Dequeue:
  - On any cycle with dequeue_in=1 and the queue not empty (start of cycle): data_out <= mem[head]; head = head+1 mod DEPTH; len -1.
  - data_out is valid one cycle after the request edge and holds its value until the next successful pop.
  - dequeue_in on an empty queue is ignored: no change to data_out, pointers or len.
  - dequeue_in held high pops one word per cycle.
- Simultaneous enqueue and dequeue:
  - Both are evaluated against the start-of-cycle flags.
  - If both are allowed, len is unchanged and both pointers advance.
  - On a full queue, only the dequeue happens; the enqueue is accepted on a later cycle once not full.
  - On an empty queue, only the enqueue happens; the new word is not bypassed to data_out.
- Pointers wrap naturally modulo DEPTH; full and empty are derived from len, not from pointer equality.
- full_out, empty_out and len_out are registered and consistent with each other on every cycle.

Optional Feature:
- Macro: FILA_ERR_EN.
- Defined:
  - Adds output err_out (1 bit, reset 0).
  - err_out is set sticky when dequeue_in=1 while empty, or when data_ready_in=1 in IDLE while full for 4 or more consecutive cycles.
  - err_out is cleared only by reset.
- Not defined: port err_out is absent; these conditions are silently handled as described in Behaviour.

Test Plan:
- Reset release, then present data_in=8'hA5 with data_ready_in=1 for 3 cycles:
  - len_out=1 and ack_out=1 one cycle after the first edge;
  - drop data_ready_in, then ack_out=0 on the next edge;
  - len_out stays 1 (no double write).
- Enqueue 8'h01..8'h08 via the handshake: full_out=1 and len_out=8. Present 8'h09: ack_out stays 0 and len_out stays 8. Pulse dequeue_in once: data_out=8'h01, then 8'h09 is accepted and full_out=1 again.
- Wrap-around: enqueue 12 words with interleaved pops (pop after every 2nd push). Popped sequence equals push order; len_out never exceeds 8.
- Simultaneous: queue holds 3 words; the dequeue_in edge coincides with an accepted enqueue. len_out stays 3 and data_out = oldest word.
- Empty pop: with len_out=0, dequeue_in=1 for 2 cycles. data_out unchanged and len_out=0; with FILA_ERR_EN defined, err_out=1.
- Reset mid-operation: queue has 5 words, state ACK; pulse reset=0 between edges. Immediately len_out=0, empty_out=1, ack_out=0, data_out=0.

Source files
------------

// File: rtl/fila_dados.sv
// Circular FIFO behind the 8-bit deserializer: ack handshake on the write side, pop-on-request read side.
// Optional sticky error flag err_out is built when FILA_ERR_EN is defined.
`timescale 1ns/1ps
module fila_dados #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clock_10KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_ready_in,
    output logic             ack_out,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] len_out,
    output logic             full_out,
    output logic             empty_out
`ifdef FILA_ERR_EN
    ,
    output logic             err_out
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } state_e;

    state_e           state_q;
    logic             ack_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  tail_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             full_q;
    logic             empty_q;
    logic [WIDTH-1:0] data_out_q;
    logic             enq;
    logic             deq;

    // Both requests are judged against the flags as they stood at the start of the cycle.
    assign enq = (state_q == StIdle) && data_ready_in && !full_q;
    assign deq = dequeue_in && !empty_q;

    always_comb begin
        len_d = len_q;
        unique case ({enq, deq})
            2'b10:   len_d = len_q + LEN_W'(1);
            2'b01:   len_d = len_q - LEN_W'(1);
            default: len_d = len_q;
        endcase
    end

    // Input handshake FSM; StAck blocks a second write until data_ready_in falls.
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enq) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                    end
                end
                StAck: begin
                    if (!data_ready_in) begin
                        state_q <= StIdle;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            len_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            data_out_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (deq) begin
                head_q     <= head_q + PtrW'(1);
                data_out_q <= mem_q[head_q];
            end
            len_q   <= len_d;
            full_q  <= (len_d == LEN_W'(DEPTH));
            empty_q <= (len_d == '0);
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clock_10KHz) begin
        if (enq) begin
            mem_q[tail_q] <= data_in;
        end
    end

    assign ack_out   = ack_q;
    assign data_out  = data_out_q;
    assign len_out   = len_q;
    assign full_out  = full_q;
    assign empty_out = empty_q;

`ifdef FILA_ERR_EN
    logic [1:0] stall_cnt_q;
    logic       err_q;
    logic       stall;

    assign stall = (state_q == StIdle) && data_ready_in && full_q;

    // Error fires on the fourth consecutive stalled cycle, or on any pop of an empty queue.
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt_q <= '0;
            end else if (stall_cnt_q != 2'd3) begin
                stall_cnt_q <= stall_cnt_q + 2'd1;
            end
            if ((dequeue_in && empty_q) || (stall && (stall_cnt_q == 2'd3))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_fila_dados.sv
// Bench for fila_dados: directed handshake/pop vectors, reference-queue scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_fila_dados;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] data_in;
    logic             data_ready_in;
    logic             ack_out;
    logic             dequeue_in;
    logic [WIDTH-1:0] data_out;
    logic [LEN_W-1:0] len_out;
    logic             full_out;
    logic             empty_out;
`ifdef FILA_ERR_EN
    logic             err_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fila_dados #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .LEN_W(LEN_W)
    ) dut (
        .clock_10KHz  (clk),
        .reset        (rst_n),
        .data_in      (data_in),
        .data_ready_in(data_ready_in),
        .ack_out      (ack_out),
        .dequeue_in   (dequeue_in),
        .data_out     (data_out),
        .len_out      (len_out),
        .full_out     (full_out),
        .empty_out    (empty_out)
`ifdef FILA_ERR_EN
        ,
        .err_out      (err_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_pops[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_idle;
    logic             m_ack;

    always @(posedge clk) begin
        logic do_enq;
        logic do_deq;
        if (!rst_n) begin
            mq.delete();
            exp_pops.delete();
            m_dout = '0;
            m_idle = 1'b1;
            m_ack  = 1'b0;
        end else begin
            do_enq = m_idle && data_ready_in && (mq.size() < DEPTH);
            do_deq = dequeue_in && (mq.size() > 0);
            if (do_deq) exp_pops.push_back(mq.pop_front());
            if (do_enq) mq.push_back(data_in);
            if (m_idle) begin
                if (do_enq) begin
                    m_idle = 1'b0;
                    m_ack  = 1'b1;
                end
            end else if (!data_ready_in) begin
                m_idle = 1'b1;
                m_ack  = 1'b0;
            end
            #1;
            if (exp_pops.size() > 0) begin
                m_dout = exp_pops.pop_front();
                chk("sb_pop_data", data_out, m_dout);
            end else begin
                chk("sb_hold_data", data_out, m_dout);
            end
            chk("sb_len", len_out, mq.size());
            chk("sb_full", full_out, mq.size() == DEPTH);
            chk("sb_empty", empty_out, mq.size() == 0);
            chk("sb_ack", ack_out, m_ack);
        end
    end

    task automatic push(input logic [WIDTH-1:0] w);
        int k;
        data_in       = w;
        data_ready_in = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack_out && k < 20);
        if (!ack_out) chk("push_ack_timeout", ack_out, 1);
        data_ready_in = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack_out && k < 20);
        if (ack_out) chk("push_release_timeout", ack_out, 0);
    endtask

    task automatic pop_n(input int n);
        dequeue_in = 1'b1;
        repeat (n) @(negedge clk);
        dequeue_in = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        data_in       = '0;
        data_ready_in = 1'b0;
        dequeue_in    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack_out, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_len", len_out, 0);
        chk("rst_full", full_out, 0);
        chk("rst_empty", empty_out, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word held for three cycles: one write only
        data_in       = 8'hA5;
        data_ready_in = 1'b1;
        @(negedge clk);
        chk("t1_len_first", len_out, 1);
        chk("t1_ack_first", ack_out, 1);
        repeat (2) @(negedge clk);
        chk("t1_len_held", len_out, 1);
        data_ready_in = 1'b0;
        @(negedge clk);
        chk("t1_ack_drop", ack_out, 0);
        chk("t1_len_after", len_out, 1);
        pop_n(1);
        chk("t1_pop", data_out, 8'hA5);

        // Fill, stall while full, free one slot, accept the stalled word
        for (int i = 1; i <= 8; i++) push(WIDTH'(i));
        chk("t2_full", full_out, 1);
        chk("t2_len", len_out, 8);
        data_in       = 8'h09;
        data_ready_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_ack", ack_out, 0);
            chk("t2_stall_len", len_out, 8);
        end
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        chk("t2_pop_data", data_out, 8'h01);
        chk("t2_pop_len", len_out, 7);
        @(negedge clk);
        chk("t2_refill_full", full_out, 1);
        chk("t2_refill_ack", ack_out, 1);
        data_ready_in = 1'b0;
        @(negedge clk);
        chk("t2_release", ack_out, 0);
        pop_n(8);
        chk("t2_drain_last", data_out, 8'h09);
        chk("t2_drain_empty", empty_out, 1);

        // Wrap-around with a pop after every second push
        for (int i = 0; i < 12; i++) begin
            push(8'h10 + WIDTH'(i));
            if (i % 2 == 1) pop_n(1);
        end
        chk("t3_len", len_out, 6);
        chk("t3_mid_pop", data_out, 8'h15);
        pop_n(6);
        chk("t3_last", data_out, 8'h1B);
        chk("t3_empty", empty_out, 1);

        // Simultaneous enqueue and dequeue on a 3-word queue
        push(8'h21);
        push(8'h22);
        push(8'h23);
        data_in       = 8'h24;
        data_ready_in = 1'b1;
        dequeue_in    = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        chk("t4_len", len_out, 3);
        chk("t4_dout", data_out, 8'h21);
        chk("t4_ack", ack_out, 1);
        data_ready_in = 1'b0;
        @(negedge clk);
        pop_n(3);
        chk("t4_drain", data_out, 8'h24);

        // Pop on empty is ignored
        pop_n(2);
        chk("t5_dout", data_out, 8'h24);
        chk("t5_len", len_out, 0);
        chk("t5_empty", empty_out, 1);
`ifdef FILA_ERR_EN
        chk("t5_err", err_out, 1);
`endif

        // Asynchronous reset while in the ack state with 5 words stored
        for (int i = 0; i < 4; i++) push(8'h31 + WIDTH'(i));
        data_in       = 8'h35;
        data_ready_in = 1'b1;
        @(negedge clk);
        chk("t6_pre_len", len_out, 5);
        chk("t6_pre_ack", ack_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_len", len_out, 0);
        chk("t6_empty", empty_out, 1);
        chk("t6_full", full_out, 0);
        chk("t6_ack", ack_out, 0);
        chk("t6_dout", data_out, 0);
`ifdef FILA_ERR_EN
        chk("t6_err", err_out, 0);
`endif
        @(negedge clk);
        rst_n         = 1'b1;
        data_ready_in = 1'b0;
        @(negedge clk);
        chk("t6_post_len", len_out, 0);
        chk("t6_post_ack", ack_out, 0);
        push(8'h5A);
        pop_n(1);
        chk("t6_restart", data_out, 8'h5A);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
